// File: rtl/ps2_kbd_pkg.sv
// Shared types and register layout for the PS/2 keyboard receiver and its CPU window.
// Holds the frame FSM states, STATUS/DATA bit positions and the register offsets decoded from addr[2].
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_OVERFLOW  = 1;
  localparam int STAT_FRAME_ERR = 2;
  localparam int STAT_COUNT_LSB = 8;

  localparam int DATA_VLD_BIT = 8;

  localparam logic OFS_DATA   = 1'b0;
  localparam logic OFS_STATUS = 1'b1;

  // A PS/2 frame is good when the parity bit makes the 9-bit total odd.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_kbd_fifo.sv
// Synchronous FIFO: head is visible the cycle after a push; pop on empty is ignored.
// Backpressure: a push while full is dropped unless a pop happens on the same edge.
module kbd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver feeding a scancode FIFO read through the MMU window; byte readable the cycle after its stop bit.
// dout is combinational; DATA reads pop at the end of the read cycle, STATUS reads clear the sticky error flags.
module ps2_kbd
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic        sel,
  input  logic        rd,
  input  logic [31:0] addr,
  output logic [31:0] dout
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             clk_s1, sync_clk, prev_clk;
  logic             dat_s1, sync_dat;
  logic             fall;
  frame_state_e     state;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             frame_ok;
  logic             push;
  logic             pop;
  logic             stat_rd;
  logic             frame_err, frame_err_set;
  logic             overflow, ovf_set;
  logic [7:0]       head;
  logic             full, empty;
  logic [CW-1:0]    count;
  logic [31:0]      count_ext;
  logic [3:0]       count_field;
  logic             unused_addr;

  assign unused_addr = ^{addr[31:3], addr[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      sync_clk <= 1'b1;
      prev_clk <= 1'b1;
      dat_s1   <= 1'b1;
      sync_dat <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      sync_clk <= clk_s1;
      prev_clk <= sync_clk;
      dat_s1   <= ps2_dat;
      sync_dat <= dat_s1;
    end
  end

  assign fall          = prev_clk & ~sync_clk;
  assign tmo_hit       = (state != ST_IDLE) & ~fall & (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
  assign frame_ok      = sync_dat & odd_parity_ok(shreg, par_bit);
  assign push          = (state == ST_STOP) & fall & frame_ok;
  assign frame_err_set = tmo_hit | ((state == ST_STOP) & fall & ~frame_ok);
  assign pop           = sel & rd & (addr[2] == OFS_DATA) & ~empty;
  assign stat_rd       = sel & rd & (addr[2] == OFS_STATUS);
  assign ovf_set       = push & full & ~pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // Set wins over the clear from a STATUS read on the same edge.
      frame_err <= frame_err_set | (frame_err & ~stat_rd);
      overflow  <= ovf_set | (overflow & ~stat_rd);

      if (state == ST_IDLE || fall || tmo_hit) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + TMO_W'(1);

      case (state)
        ST_IDLE: if (fall && !sync_dat) begin
          state  <= ST_DATA;
          bitcnt <= '0;
        end
        ST_DATA: if (fall) begin
          shreg  <= {sync_dat, shreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) state <= ST_PARITY;
        end
        ST_PARITY: if (fall) begin
          par_bit <= sync_dat;
          state   <= ST_STOP;
        end
        ST_STOP: if (fall) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (tmo_hit) state <= ST_IDLE;
    end
  end

  kbd_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (shreg),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign count_ext   = 32'(count);
  assign count_field = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  always_comb begin
    dout = '0;
    if (addr[2] == OFS_STATUS) begin
      dout[STAT_NONEMPTY]           = ~empty;
      dout[STAT_OVERFLOW]           = overflow;
      dout[STAT_FRAME_ERR]          = frame_err;
      dout[STAT_COUNT_LSB +: 4]     = count_field;
    end else if (!empty) begin
      dout[7:0]          = head;
      dout[DATA_VLD_BIT] = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_kbd.sv
// Bench for ps2_kbd: vector table, hand-written corner sequences and random frames against a queue model.
module tb_ps2_kbd;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;

  logic        clock = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_dat;
  logic        sel;
  logic        rd;
  logic [31:0] addr;
  logic [31:0] dout;

  int total = 0;
  int bad   = 0;

  ps2_kbd #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .sel     (sel),
    .rd      (rd),
    .addr    (addr),
    .dout    (dout)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: what the CPU should observe, as a plain queue plus two flags.
  logic [7:0] mq[$];
  bit         m_ferr;
  bit         m_ovf;

  function automatic void m_reset();
    mq.delete();
    m_ferr = 0;
    m_ovf  = 0;
  endfunction

  function automatic void m_frame(input logic [7:0] b, input bit bad_par);
    if (bad_par)                m_ferr = 1;
    else if (mq.size() >= DEPTH) m_ovf = 1;
    else                         mq.push_back(b);
  endfunction

  function automatic logic [31:0] m_data();
    logic [7:0] h;
    if (mq.size() == 0) return 32'h0;
    h = mq.pop_front();
    return 32'h100 | {24'h0, h};
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] r;
    r = (mq.size() << 8) | (32'(m_ferr) << 2) | (32'(m_ovf) << 1) | 32'(mq.size() != 0);
    m_ferr = 0;
    m_ovf  = 0;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic cpu_read(input logic a2, output logic [31:0] d);
    @(negedge clock);
    sel  = 1'b1;
    rd   = 1'b1;
    addr = ($urandom & ~32'h4) | (a2 ? 32'h4 : 32'h0);
    #1 d = dout;
    @(posedge clock);
    #1;
    sel  = 1'b0;
    rd   = 1'b0;
    addr = '0;
  endtask

  // One PS/2 bit; optionally a DATA read lands on the edge that samples this bit.
  task automatic ps2_bit(input logic b, input bit rd_hook, output logic [31:0] hook_d);
    @(negedge clock);
    ps2_dat = b;
    repeat (4) @(negedge clock);
    ps2_clk = 1'b0;
    hook_d  = '0;
    if (rd_hook) begin
      repeat (2) @(negedge clock);
      sel  = 1'b1;
      rd   = 1'b1;
      addr = 32'h0;
      #1 hook_d = dout;
      @(posedge clock);
      #1;
      sel = 1'b0;
      rd  = 1'b0;
      repeat (2) @(negedge clock);
    end else begin
      repeat (4) @(negedge clock);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit hook,
                            output logic [31:0] hook_d);
    logic [10:0] fr;
    logic [31:0] d;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    hook_d = '0;
    for (int i = 0; i < 11; i++) begin
      ps2_bit(fr[i], hook && i == 10, d);
      if (hook && i == 10) hook_d = d;
    end
  endtask

  task automatic rd_check(input string name, input logic a2);
    logic [31:0] d;
    logic [31:0] e;
    cpu_read(a2, d);
    e = a2 ? m_status() : m_data();
    check(name, d, e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    logic [31:0] exp_stat;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [31:0] d;
    logic [31:0] e;

    vt[0] = '{8'h1C, 0, 32'h101, 32'h11C};
    vt[1] = '{8'h1C, 1, 32'h004, 32'h000};
    vt[2] = '{8'hF0, 0, 32'h101, 32'h1F0};
    vt[3] = '{8'h5A, 0, 32'h101, 32'h15A};
    vt[4] = '{8'h00, 0, 32'h101, 32'h100};
    vt[5] = '{8'hFF, 1, 32'h004, 32'h000};
    vt[6] = '{8'hFF, 0, 32'h101, 32'h1FF};

    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    sel = 1'b0; rd = 1'b0; addr = '0;
    m_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;

    cpu_read(1'b0, d); check("reset_data", d, 32'h0);
    cpu_read(1'b1, d); check("reset_status", d, 32'h0);

    for (int i = 0; i < 7; i++) begin
      send_frame(vt[i].b, vt[i].bad_par, 0, d);
      m_frame(vt[i].b, vt[i].bad_par);
      cpu_read(1'b1, d); check($sformatf("vec%0d_status", i), d, vt[i].exp_stat);
      void'(m_status());
      cpu_read(1'b0, d); check($sformatf("vec%0d_data", i), d, vt[i].exp_data);
      void'(m_data());
    end

    send_frame(8'h1C, 0, 0, d);
    cpu_read(1'b0, d); check("1c_data", d, 32'h11C);
    cpu_read(1'b0, d); check("1c_second_data", d, 32'h0);
    cpu_read(1'b1, d); check("1c_status", d, 32'h0);

    send_frame(8'h1C, 1, 0, d);
    cpu_read(1'b1, d); check("perr_status", d, 32'h4);
    cpu_read(1'b1, d); check("perr_status_cleared", d, 32'h0);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, d);
    cpu_read(1'b1, d); check("fill_status", d, 32'h803);
    for (int i = 1; i <= 8; i++) begin
      cpu_read(1'b0, d); check($sformatf("fill_data%0d", i), d, 32'h100 + 32'(i));
    end
    cpu_read(1'b0, d); check("fill_data_empty", d, 32'h0);

    // Pop and push on the same edge while full.
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h11 + 8'(i), 0, 0, d);
      m_frame(8'h11 + 8'(i), 0);
    end
    send_frame(8'h19, 0, 1, d);
    e = m_data();
    check("full_pushpop_head", d, e);
    m_frame(8'h19, 0);
    rd_check("full_pushpop_status", 1'b1);
    for (int i = 0; i < 9; i++) rd_check($sformatf("full_pushpop_data%0d", i), 1'b0);

    // Abandoned frame: start bit plus three data bits, then idle.
    ps2_bit(1'b0, 0, d);
    for (int i = 0; i < 3; i++) ps2_bit(1'(i & 1), 0, d);
    repeat (TMO + 2) @(negedge clock);
    cpu_read(1'b1, d); check("timeout_status", d, 32'h4);
    send_frame(8'hF0, 0, 0, d);
    cpu_read(1'b0, d); check("after_timeout_data", d, 32'h1F0);

    // Reset in the middle of a frame, with a byte already queued.
    send_frame(8'h33, 0, 0, d);
    ps2_bit(1'b0, 0, d);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0, d);
    do_reset();
    cpu_read(1'b1, d); check("midreset_status", d, 32'h0);
    send_frame(8'h5A, 0, 0, d);
    cpu_read(1'b0, d); check("midreset_data", d, 32'h15A);
    cpu_read(1'b0, d); check("midreset_data_empty", d, 32'h0);

    m_reset();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit bp;
      b  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      send_frame(b, bp, 0, d);
      m_frame(b, bp);
      for (int k = $urandom_range(0, 2); k > 0; k--)
        rd_check($sformatf("rand%0d", n), 1'($urandom_range(0, 2) == 0));
    end
    rd_check("rand_final_status", 1'b1);
    while (mq.size() != 0) rd_check("rand_drain", 1'b0);
    rd_check("rand_drain_empty", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbd.md
Name: ps2_kbd

Overview:
PS/2 keyboard receiver and memory-mapped scancode FIFO.
- Deserialises 11-bit PS/2 frames from the PS2_CLK/PS2_DAT pins and checks them.
- Buffers valid scancodes and serves them to the CPU through the MMU keyboard window. Its output drives dout_kbd.
- Sits between the top-level PS/2 pins and the Mmu read mux, on the CPU data-read path.

Parameters:
FIFO_DEPTH, 8, scancode entries buffered; must be a power of 2, at least 2
TIMEOUT_CYCLES, 10000, idle clock cycles mid-frame before the partial frame is abandoned (1 ms at 10 MHz)

Ports:
clock     input   1   system clock; the only clock in the block
reset     input   1   synchronous, active-high reset
ps2_clk   input   1   raw PS/2 clock pin, asynchronous
ps2_dat   input   1   raw PS/2 data pin, asynchronous
sel       input   1   keyboard window selected by Mmu
rd        input   1   one-cycle CPU read strobe
addr      input   32  CPU data address; only addr[2] is decoded (0 = DATA, 1 = STATUS)
dout      output  32  read data, combinational from addr and current state

Behaviour:
Reset and clocking
- One clock; reset is synchronous and active-high.
- Reset clears: FIFO (empty), sync flops (to 1), FSM (IDLE), sticky flags, timeout counter.
- After reset, dout = 0 for DATA and 0 for STATUS.
- Reset mid-frame discards the partial frame with no error flag.

Input synchronisation
- ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
- A third flop on the clock path gives prev_clk.
- fall = prev_clk & ~sync_clk. Data is sampled only on a cycle where fall = 1.

Frame FSM (IDLE, DATA, PARITY, STOP)
- IDLE: on fall, if dat = 0 then go to DATA with bitcnt = 0. If dat = 1, ignore the edge (glitch); no error.
- DATA: on fall, shift right with dat entering bit 7 (LSB-first). After the 8th bit go to PARITY.
- PARITY: on fall, capture the parity bit and go to STOP.
- STOP: on fall, test stop == 1 and odd parity (^{data, parity} == 1).
  - Pass: push data into the FIFO.
  - Fail: set frame_err and discard.
  - Either way, return to IDLE.
- Timeout:
  - In any state other than IDLE, the timeout counter increments each cycle without fall and clears on fall.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, set frame_err, clear the counter.
  - In IDLE the counter is held at 0.

FIFO and read side
- Push happens on the clock edge that samples the stop bit; the entry is visible the following cycle.
- pop = sel & rd & ~addr[2] & ~empty, taking effect on that cycle's edge.
- Pop on empty is a no-op.
- Push while full with no pop: drop the new byte and set overflow.
- Push and pop on the same cycle while full: both occur, count unchanged, no overflow.
- Push and pop on the same cycle while not full: both occur, count unchanged.

DATA read (addr[2] = 0)
- Non-empty: dout = {23'b0, 1'b1, head[7:0]}.
- Empty: dout = 0.
- A read returns the head, and the pop takes effect at the end of that read cycle.

STATUS read (addr[2] = 1)
- dout = {20'b0, count[3:0], 5'b0, frame_err, overflow, ~empty}.
- count saturates the field at FIFO_DEPTH; the field is sized for the default depth of 8.
- A STATUS read (sel & rd & addr[2]) clears frame_err and overflow on its edge. If a new error is set in the same cycle, set wins.
- STATUS reads never pop.

Decomposition:
- Package kbd_pkg holds:
  - the FSM state enum;
  - the STATUS bit positions (NONEMPTY = 0, OVERFLOW = 1, FRAME_ERR = 2, COUNT_LSB = 8);
  - the valid-bit position in DATA (8);
  - the DATA/STATUS offset constants.
- Sub-module kbd_fifo: synchronous FIFO on clock/reset, parameterised on width and depth.
  - Ports: push, pop, din, head, full, empty, count.
  - Implements the simultaneous push/pop-when-full rule.
- ps2_kbd itself holds the synchroniser, FSM, timeout counter, sticky flags and read mux.

Test Plan:
- Send 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), then read DATA → 0x0000011C. A second read → 0x00000000. STATUS → 0x00000000.
- Send 0x1C with parity 1 → nothing pushed. STATUS → 0x00000004; a second STATUS read → 0x00000000.
- Send 0x01..0x09 with no reads → STATUS → 0x00000803. Eight DATA reads → 0x101..0x108 in order; the ninth read → 0.
- Fill the FIFO, then issue a DATA read on the exact cycle the stop bit of a 9th frame is sampled → no overflow, count stays 8, the new byte is last in order.
- Send a start bit plus 3 data bits, hold ps2_clk high for TIMEOUT_CYCLES+2 cycles → frame_err set. Then send a full 0xF0 frame (parity 1) → DATA read → 0x000001F0.
- Assert reset after 5 bits of a frame, then send 0x5A → only 0x15A is read. STATUS clean after reset.
